// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the register-file write port plus pending-write scoreboard (bypass: WB_BYPASS_EN).
// Latency: grant to wb_we/wb_addr/wb_data is 1 cycle; scoreboard queries and issue_ready are combinational.
// Backpressure: ungranted requesters hold valid/addr/data; issue_ready drops while the destination is pending.
module regfile_wb_arbiter #(
  parameter int N_REQ = 3,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic                wb_we,
  output logic [AW-1:0]       wb_addr,
  output logic [DW-1:0]       wb_data,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_dest,
  output logic                issue_ready,
  input  logic [AW-1:0]       rs2_addr,
  input  logic [AW-1:0]       rs3_addr,
  output logic                rs2_busy,
  output logic                rs3_busy,
  output logic [DW-1:0]       rs2_fwd,
  output logic [DW-1:0]       rs3_fwd
);

  localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int NREG = 1 << AW;

  logic [PW-1:0]   rr_ptr;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            gnt_any;
  logic [PW-1:0]   gnt_idx;
  logic [PW:0]     scan;
  logic [AW-1:0]   gnt_addr;
  logic [DW-1:0]   gnt_data;

  // Scan from rr_ptr with wrap; the first valid requester wins.
  always_comb begin
    req_ready = '0;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    scan      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = {1'b0, rr_ptr} + (PW+1)'(k);
      if (scan >= (PW+1)'(N_REQ)) scan = scan - (PW+1)'(N_REQ);
      if (!gnt_any && req_valid[scan[PW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = scan[PW-1:0];
      end
    end
    if (gnt_any && rst_n) req_ready[gnt_idx] = 1'b1;
  end

  assign gnt_addr = req_addr[gnt_idx*AW +: AW];
  assign gnt_data = req_data[gnt_idx*DW +: DW];

  // Register zero is constant, so its writes are consumed but never enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      rr_ptr  <= '0;
    end else if (gnt_any) begin
      wb_we   <= (gnt_addr != '0);
      wb_addr <= gnt_addr;
      wb_data <= gnt_data;
      rr_ptr  <= (gnt_idx == PW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end else begin
      wb_we   <= 1'b0;
    end
  end

  assign issue_ready = ~busy[issue_dest] | (issue_dest == '0);

  // Clear first so a same-edge issue to the register being written keeps it pending.
  always_comb begin
    busy_nxt = busy;
    if (wb_we) busy_nxt[wb_addr] = 1'b0;
    if (issue_valid && issue_ready && (issue_dest != '0)) busy_nxt[issue_dest] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

`ifdef WB_BYPASS_EN
  logic rs2_hit;
  logic rs3_hit;

  assign rs2_hit  = wb_we && (wb_addr == rs2_addr) && (rs2_addr != '0);
  assign rs3_hit  = wb_we && (wb_addr == rs3_addr) && (rs3_addr != '0);
  assign rs2_busy = busy[rs2_addr] & ~rs2_hit;
  assign rs3_busy = busy[rs3_addr] & ~rs3_hit;
  assign rs2_fwd  = rs2_hit ? wb_data : '0;
  assign rs3_fwd  = rs3_hit ? wb_data : '0;
`else
  assign rs2_busy = busy[rs2_addr];
  assign rs3_busy = busy[rs3_addr];
  assign rs2_fwd  = '0;
  assign rs3_fwd  = '0;
`endif

endmodule
